// File: rtl/control_unit_pkg.sv
// Shared decode constants and control encodings for the control unit,
// datapath and pipeline registers.
package control_unit_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_NOP  = 6'b000000;
  localparam logic [5:0] FN_CMCO = 6'b000000;

  typedef enum logic [1:0] {
    WA_RT = 2'b00,
    WA_RD = 2'b01,
    WA_RA = 2'b10
  } wa_sel_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_OR   = 3'b010,
    ALU_LUI  = 3'b011,
    ALU_PC8  = 3'b100,
    ALU_CMCO = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    NPC_PC4    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_REG    = 2'b11
  } npc_sel_e;

  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic cmco;
    logic nop;
    logic illegal;
  } instr_flags_t;

  // Bit layout matches the 16-bit pipeline register ctrl_q.
  typedef struct packed {
    logic      reg_write;
    logic      wd_sel_alu;
    logic      mem_write;
    logic      alu_src_imm;
    logic      ext_sign;
    wa_sel_e   wa_sel;
    alu_ctrl_e alu_ctrl;
    npc_sel_e  npc_sel;
    logic      illegal;
    logic [2:0] pad;
  } ctrl_word_t;

endpackage

// File: rtl/control_unit_if.sv
// Instruction-field inputs and decoded control outputs of the control unit.
interface control_unit_if;
  logic [5:0]  op;
  logic [5:0]  fuc;
  logic        addu, subu, jr, ori, lui, lw, sw, beq, j, jal, cmco;
  logic        nop, illegal;
  logic        reg_write, wd_sel_alu, mem_write, alu_src_imm, ext_sign;
  logic [1:0]  wa_sel;
  logic [2:0]  alu_ctrl;
  logic [1:0]  npc_sel;
  logic [15:0] ctrl_q;

  modport master (
    output op, fuc,
    input  addu, subu, jr, ori, lui, lw, sw, beq, j, jal, cmco, nop, illegal,
    input  reg_write, wd_sel_alu, mem_write, alu_src_imm, ext_sign,
    input  wa_sel, alu_ctrl, npc_sel, ctrl_q
  );

  modport slave (
    input  op, fuc,
    output addu, subu, jr, ori, lui, lw, sw, beq, j, jal, cmco, nop, illegal,
    output reg_write, wd_sel_alu, mem_write, alu_src_imm, ext_sign,
    output wa_sel, alu_ctrl, npc_sel, ctrl_q
  );
endinterface

// File: rtl/control_unit_decode.sv
// Pure combinational op/funct decode into one-hot instruction flags.
module control_decode
  import control_unit_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   fuc,
  output instr_flags_t flags
);

  // NOTE: every field gets a default first so no path through the case
  // leaves a flag unassigned, which would infer a latch.
  always_comb begin
    flags = '0;
    case (op)
      OP_RTYPE: begin
        case (fuc)
          FN_ADDU: flags.addu    = 1'b1;
          FN_SUBU: flags.subu    = 1'b1;
          FN_JR:   flags.jr      = 1'b1;
          FN_NOP:  flags.nop     = 1'b1;
          default: flags.illegal = 1'b1;
        endcase
      end
      OP_ORI:      flags.ori = 1'b1;
      OP_LUI:      flags.lui = 1'b1;
      OP_LW:       flags.lw  = 1'b1;
      OP_SW:       flags.sw  = 1'b1;
      OP_BEQ:      flags.beq = 1'b1;
      OP_J:        flags.j   = 1'b1;
      OP_JAL:      flags.jal = 1'b1;
      OP_SPECIAL2: begin
        if (fuc == FN_CMCO) flags.cmco    = 1'b1;
        else                flags.illegal = 1'b1;
      end
      default:     flags.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main control unit: decodes op/fuc into datapath controls and keeps a
// one-cycle registered copy for the next pipeline stage.
module control_unit
  import control_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  control_unit_if.slave bus
);

  instr_flags_t flags;
  ctrl_word_t   ctrl;
  ctrl_word_t   ctrl_q_r;

  control_decode u_decode (
    .op    (bus.op),
    .fuc   (bus.fuc),
    .flags (flags)
  );

  // Flags are one-hot, so nop/illegal leave every derived control at zero.
  always_comb begin
    ctrl             = '0;
    ctrl.reg_write   = flags.addu | flags.subu | flags.lw | flags.ori |
                       flags.lui  | flags.jal  | flags.cmco;
    ctrl.wd_sel_alu  = flags.addu | flags.subu | flags.lui | flags.ori |
                       flags.jal  | flags.cmco;
    ctrl.mem_write   = flags.sw;
    ctrl.alu_src_imm = flags.ori | flags.lui | flags.lw | flags.sw;
    ctrl.ext_sign    = flags.lw  | flags.sw  | flags.beq;
    ctrl.illegal     = flags.illegal;

    if (flags.addu || flags.subu || flags.cmco) ctrl.wa_sel = WA_RD;
    else if (flags.jal)                         ctrl.wa_sel = WA_RA;
    else                                        ctrl.wa_sel = WA_RT;

    if (flags.subu || flags.beq) ctrl.alu_ctrl = ALU_SUB;
    else if (flags.ori)          ctrl.alu_ctrl = ALU_OR;
    else if (flags.lui)          ctrl.alu_ctrl = ALU_LUI;
    else if (flags.jal)          ctrl.alu_ctrl = ALU_PC8;
    else if (flags.cmco)         ctrl.alu_ctrl = ALU_CMCO;
    else                         ctrl.alu_ctrl = ALU_ADD;

    if (flags.beq)                ctrl.npc_sel = NPC_BRANCH;
    else if (flags.j || flags.jal) ctrl.npc_sel = NPC_JUMP;
    else if (flags.jr)            ctrl.npc_sel = NPC_REG;
    else                          ctrl.npc_sel = NPC_PC4;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_q_r <= '0;
    else        ctrl_q_r <= ctrl;
  end

  assign bus.addu        = flags.addu;
  assign bus.subu        = flags.subu;
  assign bus.jr          = flags.jr;
  assign bus.ori         = flags.ori;
  assign bus.lui         = flags.lui;
  assign bus.lw          = flags.lw;
  assign bus.sw          = flags.sw;
  assign bus.beq         = flags.beq;
  assign bus.j           = flags.j;
  assign bus.jal         = flags.jal;
  assign bus.cmco        = flags.cmco;
  assign bus.nop         = flags.nop;
  assign bus.illegal     = flags.illegal;
  assign bus.reg_write   = ctrl.reg_write;
  assign bus.wd_sel_alu  = ctrl.wd_sel_alu;
  assign bus.mem_write   = ctrl.mem_write;
  assign bus.alu_src_imm = ctrl.alu_src_imm;
  assign bus.ext_sign    = ctrl.ext_sign;
  assign bus.wa_sel      = ctrl.wa_sel;
  assign bus.alu_ctrl    = ctrl.alu_ctrl;
  assign bus.npc_sel     = ctrl.npc_sel;
  assign bus.ctrl_q      = ctrl_q_r;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes model expectations,
// a negedge monitor pops them and compares against the DUT.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst_n;

  control_unit_if bus ();

  control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fuc;
    logic [12:0] exp_flags;
    logic [15:0] exp_ctrl;
    logic [15:0] exp_q;
  } entry_t;

  entry_t sb[$];
  logic [15:0] last_ctrl = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: instruction index in flag-vector order
  // addu subu jr ori lui lw sw beq j jal cmco nop illegal.
  function automatic int instr_id(input logic [5:0] op, input logic [5:0] fuc);
    case (op)
      6'b000000: begin
        if (fuc == 6'b100001) return 0;
        if (fuc == 6'b100011) return 1;
        if (fuc == 6'b001000) return 2;
        if (fuc == 6'b000000) return 11;
        return 12;
      end
      6'b001101: return 3;
      6'b001111: return 4;
      6'b100011: return 5;
      6'b101011: return 6;
      6'b000100: return 7;
      6'b000010: return 8;
      6'b000011: return 9;
      6'b011100: return (fuc == 6'b000000) ? 10 : 12;
      default:   return 12;
    endcase
  endfunction

  function automatic logic [15:0] mk(input logic rw, input logic wd, input logic mw,
                                     input logic ais, input logic es, input logic [1:0] wa,
                                     input logic [2:0] alu, input logic [1:0] npc,
                                     input logic ill);
    return {rw, wd, mw, ais, es, wa, alu, npc, ill, 3'b000};
  endfunction

  function automatic logic [15:0] model_ctrl(input int id);
    case (id)
      0:  return mk(1, 1, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0);
      1:  return mk(1, 1, 0, 0, 0, 2'b01, 3'b001, 2'b00, 0);
      2:  return mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b11, 0);
      3:  return mk(1, 1, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0);
      4:  return mk(1, 1, 0, 1, 0, 2'b00, 3'b011, 2'b00, 0);
      5:  return mk(1, 0, 0, 1, 1, 2'b00, 3'b000, 2'b00, 0);
      6:  return mk(0, 0, 1, 1, 1, 2'b00, 3'b000, 2'b00, 0);
      7:  return mk(0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 0);
      8:  return mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0);
      9:  return mk(1, 1, 0, 0, 0, 2'b10, 3'b100, 2'b10, 0);
      10: return mk(1, 1, 0, 0, 0, 2'b01, 3'b101, 2'b00, 0);
      11: return 16'h0000;
      default: return mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 1);
    endcase
  endfunction

  function automatic logic [12:0] dut_flags();
    return {bus.addu, bus.subu, bus.jr, bus.ori, bus.lui, bus.lw, bus.sw,
            bus.beq, bus.j, bus.jal, bus.cmco, bus.nop, bus.illegal};
  endfunction

  function automatic logic [15:0] dut_ctrl();
    return {bus.reg_write, bus.wd_sel_alu, bus.mem_write, bus.alu_src_imm,
            bus.ext_sign, bus.wa_sel, bus.alu_ctrl, bus.npc_sel, bus.illegal, 3'b000};
  endfunction

  // Drive one instruction just after a rising edge and record expectations.
  task automatic issue(input logic [5:0] op, input logic [5:0] fuc);
    entry_t e;
    int id;
    @(posedge clk);
    e.exp_q = rst_n ? last_ctrl : 16'h0000;
    #1;
    bus.op  = op;
    bus.fuc = fuc;
    id = instr_id(op, fuc);
    e.op        = op;
    e.fuc       = fuc;
    e.exp_flags = 13'h1000 >> id;
    e.exp_ctrl  = model_ctrl(id);
    last_ctrl   = e.exp_ctrl;
    sb.push_back(e);
  endtask

  initial begin : monitor
    entry_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("flags op=%b fuc=%b", e.op, e.fuc), 32'(dut_flags()), 32'(e.exp_flags));
        check($sformatf("onehot op=%b fuc=%b", e.op, e.fuc), 32'($countones(dut_flags()) <= 1), 32'd1);
        check($sformatf("ctrl op=%b fuc=%b", e.op, e.fuc), 32'(dut_ctrl()), 32'(e.exp_ctrl));
        check($sformatf("ctrl_q op=%b fuc=%b", e.op, e.fuc), 32'(bus.ctrl_q), 32'(e.exp_q));
      end
    end
  end

  logic [5:0] legal_op  [11] = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001111,
                                 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011,
                                 6'b011100};
  logic [5:0] legal_fuc [11] = '{6'b100001, 6'b100011, 6'b001000, 6'b000000, 6'b000000,
                                 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                 6'b000000};

  initial begin : stimulus
    logic [11:0] pair;
    logic [15:0] ori_ctrl;
    rst_n   = 1'b0;
    bus.op  = 6'b000000;
    bus.fuc = 6'b000000;
    #2;
    check("reset ctrl_q", 32'(bus.ctrl_q), 32'd0);

    // Controls keep flowing combinationally while ctrl_q is held in reset.
    issue(6'b000000, 6'b100001);
    issue(6'b000011, 6'b000000);
    @(negedge clk);
    #2 rst_n = 1'b1;

    issue(6'b000000, 6'b100001);
    issue(6'b100011, 6'b010101);
    issue(6'b000011, 6'b111111);
    issue(6'b000000, 6'b001000);
    issue(6'b111111, 6'b000000);
    issue(6'b000000, 6'b000000);
    issue(6'b001101, 6'b000000);
    issue(6'b001101, 6'b000000);

    // Mid-cycle reset pulse: ctrl_q clears at once, decode is untouched.
    ori_ctrl = model_ctrl(3);
    @(negedge clk);
    #2;
    check("ctrl_q holds ori", 32'(bus.ctrl_q), 32'(ori_ctrl));
    rst_n = 1'b0;
    #1;
    check("async reset ctrl_q", 32'(bus.ctrl_q), 32'd0);
    check("ctrl during reset", 32'(dut_ctrl()), 32'(ori_ctrl));
    check("flags during reset", 32'(dut_flags()), 32'(13'h1000 >> 3));
    #1 rst_n = 1'b1;

    issue(6'b000100, 6'b000000);
    issue(6'b101011, 6'b000000);

    for (int i = 0; i < 4096; i++) begin
      pair = 12'(i);
      issue(pair[11:6], pair[5:0]);
    end

    for (int i = 0; i < 400; i++) begin
      int k;
      if ($urandom_range(1, 0) == 1) begin
        k = $urandom_range(10, 0);
        issue(legal_op[k], legal_fuc[k]);
      end else begin
        issue(6'($urandom), 6'($urandom));
      end
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  input  1  single clock; all registered outputs update on the rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset; clears every registered output immediately.
REQ-003 op  input  6  instruction bits [31:26].
REQ-004 fuc  input  6  instruction bits [5:0].
REQ-005 addu, subu, jr, ori, lui, lw, sw, beq, j, jal, cmco  output  1 each  combinational one-hot instruction flags.
REQ-006 nop, illegal  output  1 each  combinational; all-zero instruction / unrecognised encoding.
REQ-007 reg_write  output  1  combinational; instruction writes the register file.
REQ-008 wd_sel_alu  output  1  combinational; 1 selects ALU result as write data, 0 selects memory data.
REQ-009 mem_write  output  1  combinational; data memory store.
REQ-010 alu_src_imm  output  1  combinational; ALU operand B is the extended immediate.
REQ-011 ext_sign  output  1  combinational; 1 sign-extends, 0 zero-extends imm16.
REQ-012 wa_sel  output  2  combinational; 00 rt, 01 rd, 10 constant 31.
REQ-013 alu_ctrl  output  3  combinational; 000 add, 001 sub, 010 or, 011 lui-shift, 100 pass-PC+8, 101 cmco.
REQ-014 npc_sel  output  2  combinational; 00 PC+4, 01 branch, 10 jump-imm26, 11 register.
REQ-015 ctrl_q  output  16  registered copy of {reg_write, wd_sel_alu, mem_write, alu_src_imm, ext_sign, wa_sel, alu_ctrl, npc_sel, illegal, 3'b000}.

Function
REQ-016 Decode SHALL be: op 000000 with fuc 100001 addu, 100011 subu, 001000 jr; op 001101 ori; 001111 lui; 100011 lw; 101011 sw; 000100 beq; 000010 j; 000011 jal; op 011100 with fuc 000000 cmco.
REQ-017 At most one instruction flag SHALL be high for any input.
REQ-018 op=000000 and fuc=000000 SHALL raise nop only (not illegal); all other unlisted encodings SHALL raise illegal only.
REQ-019 reg_write = addu|subu|lw|ori|lui|jal|cmco.
REQ-020 wd_sel_alu = addu|subu|lui|ori|jal|cmco; 0 for all others.
REQ-021 mem_write = sw; alu_src_imm = ori|lui|lw|sw; ext_sign = lw|sw|beq.
REQ-022 wa_sel = 01 for addu/subu/cmco, 10 for jal, 00 otherwise.
REQ-023 alu_ctrl: addu/lw/sw 000, subu/beq 001, ori 010, lui 011, jal 100, cmco 101, others 000.
REQ-024 npc_sel: beq 01, j/jal 10, jr 11, others 00 (branch-taken decision is external).
REQ-025 For illegal or nop all derived controls SHALL be 0 (no write, no store, PC+4).
REQ-026 Combinational outputs SHALL have zero-cycle latency, independent of clk and rst_n.
REQ-027 ctrl_q SHALL capture the current derived controls each rising edge (1-cycle latency), no enable.

Reset
REQ-028 rst_n low SHALL force ctrl_q to 0 asynchronously; held 0 while low.
REQ-029 First rising edge after rst_n deassertion SHALL load ctrl_q normally.
REQ-030 Reset SHALL not affect combinational outputs.

Structure
REQ-031 Opcode/funct constants, wa_sel, alu_ctrl and npc_sel encodings SHALL live in a shared package used by datapath and pipeline registers.
REQ-032 One sub-module control_decode (pure combinational op/fuc to flags) is natural; derived logic and ctrl_q register remain in control_unit.

Verification
REQ-033 op=000000, fuc=100001 -> addu=1, reg_write=1, wd_sel_alu=1, wa_sel=01, alu_ctrl=000.
REQ-034 op=100011 -> lw=1, reg_write=1, wd_sel_alu=0, alu_src_imm=1, ext_sign=1, wa_sel=00.
REQ-035 op=000011 -> jal=1, reg_write=1, wa_sel=10, alu_ctrl=100, npc_sel=10; op=000000 fuc=001000 -> jr=1, reg_write=0, npc_sel=11.
REQ-036 op=111111 -> illegal=1, every flag and derived control 0; op=0,fuc=0 -> nop=1, illegal=0.
REQ-037 Drive ori, clock once -> ctrl_q holds ori controls; assert rst_n low between edges -> ctrl_q=0 immediately, combinational outputs unchanged.
REQ-038 Exhaustive sweep of all 4096 op/fuc pairs -> at most one flag high, flags match REQ-016 table.
